// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor: hash, saturating counter step,
// weakly-not-taken init value and the PHT sweep FSM encoding.
package bp_pkg;

  localparam int IDX_W_MAX = 16;
  localparam int CTR_W_MAX = 4;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } bp_state_e;

  // Callers zero-extend both operands to IDX_W_MAX and truncate the result.
  function automatic logic [IDX_W_MAX-1:0] hash_idx(input logic [IDX_W_MAX-1:0] pc_bits,
                                                     input logic [IDX_W_MAX-1:0] ghr_bits);
    return pc_bits ^ ghr_bits;
  endfunction

  function automatic logic [CTR_W_MAX-1:0] sat_next(input logic [CTR_W_MAX-1:0] ctr,
                                                     input logic                 taken,
                                                     input int                   ctr_w);
    logic [CTR_W_MAX-1:0] ctr_max;
    ctr_max = CTR_W_MAX'((1 << ctr_w) - 1);
    if (taken) return (ctr == ctr_max) ? ctr : ctr + 1'b1;
    else       return (ctr == '0)      ? ctr : ctr - 1'b1;
  endfunction

  // Weakly not-taken: 2**(ctr_w-1)-1.
  function automatic logic [CTR_W_MAX-1:0] wnt_value(input int ctr_w);
    return CTR_W_MAX'((1 << (ctr_w - 1)) - 1);
  endfunction

endpackage

// File: rtl/bp_sat_counter_table.sv
// PHT of saturating counters with a post-reset init sweep and one shared write port.
// Optional PHT_BYPASS_EN forwards a same-cycle update into the lookup result.
module bp_sat_counter_table
  import bp_pkg::*;
#(
  parameter int IDX_W = 8,
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             init_busy,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [CTR_W-1:0] WNT = CTR_W'(wnt_value(CTR_W));

  logic [CTR_W-1:0] pht [DEPTH];

  bp_state_e        state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [CTR_W-1:0] wr_data;
  logic [CTR_W-1:0] upd_ctr_next;

  assign upd_ctr_next = CTR_W'(sat_next(CTR_W_MAX'(pht[upd_idx]), upd_taken, CTR_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // NOTE: every output of this block is defaulted first so no path leaves a latch behind.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    wr_en     = 1'b0;
    wr_idx    = ptr;
    wr_data   = WNT;
    case (state)
      ST_INIT: begin
        wr_en   = 1'b1;
        ptr_nxt = ptr + 1'b1;
        if (ptr == '1) state_nxt = ST_READY;
      end
      ST_READY: begin
        if (upd_en) begin
          wr_en   = 1'b1;
          wr_idx  = upd_idx;
          wr_data = upd_ctr_next;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // NOTE: the array has no reset so it maps onto RAM; the INIT sweep gives it a known value.
  always_ff @(posedge clk) begin
    if (wr_en) pht[wr_idx] <= wr_data;
  end

  assign init_busy = (state == ST_INIT);

`ifdef PHT_BYPASS_EN
  assign rd_taken = (upd_en && (state == ST_READY) && (upd_idx == rd_idx))
                    ? upd_ctr_next[CTR_W-1] : pht[rd_idx][CTR_W-1];
`else
  assign rd_taken = pht[rd_idx][CTR_W-1];
`endif

endmodule

// File: rtl/gshare_predictor.sv
// Gshare predictor top: GHR, PC/GHR hash and registered prediction outputs.
// Build with PHT_BYPASS_EN to forward a same-index update into the prediction.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int PHT_IDX_W = 8,
  parameter int GHR_LEN   = 8,
  parameter int CTR_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 init_busy,
  input  logic                 pred_req,
  input  logic [PC_WIDTH-1:0]  pred_pc,
  output logic                 pred_valid,
  output logic                 pred_taken,
  output logic [PHT_IDX_W-1:0] pred_idx,
  input  logic                 upd_valid,
  input  logic [PHT_IDX_W-1:0] upd_idx,
  input  logic                 upd_taken,
  output logic [GHR_LEN-1:0]   ghr_out
);

  logic [GHR_LEN-1:0]   ghr, ghr_nxt;
  logic [PHT_IDX_W-1:0] ghr_ext;
  logic [PHT_IDX_W-1:0] lookup_idx;
  logic                 lookup_taken;
  logic                 ready;

  // PC bits outside the index window never reach the hash.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[PC_WIDTH-1:PHT_IDX_W+2], pred_pc[1:0]};

  always_comb begin
    ghr_ext              = '0;
    ghr_ext[GHR_LEN-1:0] = ghr;
  end

  assign lookup_idx = PHT_IDX_W'(hash_idx(IDX_W_MAX'(pred_pc[PHT_IDX_W+1:2]),
                                          IDX_W_MAX'(ghr_ext)));
  assign ready      = ~init_busy;

  bp_sat_counter_table #(
    .IDX_W(PHT_IDX_W),
    .CTR_W(CTR_W)
  ) u_pht (
    .clk      (clk),
    .rst      (rst),
    .init_busy(init_busy),
    .rd_idx   (lookup_idx),
    .rd_taken (lookup_taken),
    .upd_en   (upd_valid),
    .upd_idx  (upd_idx),
    .upd_taken(upd_taken)
  );

  if (GHR_LEN == 1) begin : g_ghr_1
    assign ghr_nxt = upd_taken;
  end else begin : g_ghr_n
    assign ghr_nxt = {ghr[GHR_LEN-2:0], upd_taken};
  end

  // NOTE: non-blocking update, so a lookup on the same edge hashes the pre-update GHR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      ghr <= '0;
    else if (upd_valid && ready)  ghr <= ghr_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_idx   <= '0;
    end else begin
      pred_valid <= pred_req && ready;
      if (pred_req && ready) begin
        pred_idx   <= lookup_idx;
        pred_taken <= lookup_taken;
      end
    end
  end

  assign ghr_out = ghr;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed and random bench for gshare_predictor (default parameters) with a
// behavioural PHT/GHR model and a prediction scoreboard.
module tb_gshare_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_busy;
  logic        pred_req;
  logic [31:0] pred_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [7:0]  pred_idx;
  logic        upd_valid;
  logic [7:0]  upd_idx;
  logic        upd_taken;
  logic [7:0]  ghr_out;

  gshare_predictor #(
    .PC_WIDTH (32),
    .PHT_IDX_W(8),
    .GHR_LEN  (8),
    .CTR_W    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy),
    .pred_req  (pred_req),
    .pred_pc   (pred_pc),
    .pred_valid(pred_valid),
    .pred_taken(pred_taken),
    .pred_idx  (pred_idx),
    .upd_valid (upd_valid),
    .upd_idx   (upd_idx),
    .upd_taken (upd_taken),
    .ghr_out   (ghr_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] idx;
    logic       taken;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] mpht [256];
  logic [7:0] mghr;
  bit         m_ready;
  int         vectors;
  int         miscompares;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] msat(input logic [1:0] c, input logic t);
    if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  function automatic logic [31:0] pc_for(input logic [7:0] idx);
    return {22'd0, idx ^ mghr, 2'b00};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mpht[i] = 2'd1;
    mghr = 8'h00;
    sb.delete();
  endtask

  task automatic clear_inputs();
    pred_req  = 1'b0;
    pred_pc   = 32'h0;
    upd_valid = 1'b0;
    upd_idx   = 8'h0;
    upd_taken = 1'b0;
  endtask

  // One clock: model the current inputs, advance, then score the registered outputs.
  task automatic cycle();
    exp_t       e;
    logic [7:0] li;
    logic [1:0] nv;
    if (m_ready && pred_req) begin
      li      = pred_pc[9:2] ^ mghr;
      e.idx   = li;
      e.taken = mpht[li][1];
`ifdef PHT_BYPASS_EN
      if (upd_valid && upd_idx == li) begin
        nv      = msat(mpht[li], upd_taken);
        e.taken = nv[1];
      end
`endif
      sb.push_back(e);
    end
    if (m_ready && upd_valid) begin
      mpht[upd_idx] = msat(mpht[upd_idx], upd_taken);
      mghr          = {mghr[6:0], upd_taken};
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("pred_valid", pred_valid, 1);
      check("pred_idx", pred_idx, e.idx);
      check("pred_taken", pred_taken, e.taken);
    end else begin
      check("pred_valid_idle", pred_valid, 0);
    end
    check("ghr", ghr_out, mghr);
  endtask

  task automatic predict(input logic [31:0] pc);
    pred_req = 1'b1; pred_pc = pc;
    cycle();
    clear_inputs();
  endtask

  task automatic update(input logic [7:0] i, input logic t);
    upd_valid = 1'b1; upd_idx = i; upd_taken = t;
    cycle();
    clear_inputs();
  endtask

  task automatic both(input logic [31:0] pc, input logic [7:0] i, input logic t);
    pred_req = 1'b1; pred_pc = pc;
    upd_valid = 1'b1; upd_idx = i; upd_taken = t;
    cycle();
    clear_inputs();
  endtask

  // Runs the sweep with garbage inputs; abort_at>0 stops early, else expects exactly 256 busy cycles.
  task automatic wait_init(input int abort_at);
    int n    = 0;
    bit done = 1'b0;
    m_ready = 1'b0;
    while (!done && n < 1000) begin
      pred_req  = 1'($urandom);
      pred_pc   = $urandom;
      upd_valid = 1'($urandom);
      upd_idx   = 8'($urandom);
      upd_taken = 1'($urandom);
      @(posedge clk);
      #1;
      n++;
      check("init_no_valid", pred_valid, 0);
      check("init_ghr_hold", ghr_out, 0);
      if (abort_at != 0 && n == abort_at) done = 1'b1;
      else if (!init_busy)                done = 1'b1;
    end
    clear_inputs();
    if (abort_at == 0) begin
      check("init_len", 32'(n), 256);
      m_ready = 1'b1;
    end else begin
      check("init_busy_mid", init_busy, 1);
    end
  endtask

  task automatic sweep_all_wnt();
    for (int i = 0; i < 256; i++) begin
      predict({22'd0, 8'(i), 2'b00});
      check("wnt_taken", pred_taken, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rpc;
    vectors     = 0;
    miscompares = 0;
    m_ready     = 1'b0;
    model_reset();
    clear_inputs();
    rst = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", pred_valid, 0);
    check("rst_taken", pred_taken, 0);
    check("rst_idx", pred_idx, 0);
    check("rst_ghr", ghr_out, 0);
    check("rst_busy", init_busy, 1);
    rst = 1'b0;

    // Reset pulse at sweep cycle 100, then a full sweep
    wait_init(100);
    rst = 1'b1;
    #1;
    check("midsweep_busy", init_busy, 1);
    check("midsweep_valid", pred_valid, 0);
    check("midsweep_ghr", ghr_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_init(0);

    // First lookups after init: never taken, hash with GHR=0
    predict(32'h0000_0040);
    check("first_idx", pred_idx, 8'h10);
    check("first_taken", pred_taken, 0);
    for (int i = 0; i < 3; i++) begin
      rpc = $urandom;
      predict(rpc);
      check("first_rand_taken", pred_taken, 0);
    end
    sweep_all_wnt();

    // Saturation at idx 0x10
    repeat (3) update(8'h10, 1'b1);
    predict(pc_for(8'h10));
    check("sat3_idx", pred_idx, 8'h10);
    check("sat3_taken", pred_taken, 1);
    update(8'h10, 1'b1);
    update(8'h10, 1'b0);
    predict(pc_for(8'h10));
    check("sat_nowrap_taken", pred_taken, 1);
    check("sat_ghr", ghr_out, 8'h1E);

    // Alternating history 0,1,0,1,...
    for (int i = 0; i < 8; i++) update(8'h20, 1'(i % 2));
    check("alt_ghr", ghr_out, 8'h55);
    predict(32'h0000_0040);
    check("alt_idx", pred_idx, 8'h45);

    // Same-edge lookup and update on a counter at 1
    both(pc_for(8'h33), 8'h33, 1'b1);
    check("collide_idx", pred_idx, 8'h33);
`ifdef PHT_BYPASS_EN
    check("collide_taken", pred_taken, 1);
`else
    check("collide_taken", pred_taken, 0);
`endif

    // Back-to-back updates to one index must all land
    update(8'h80, 1'b1);
    update(8'h80, 1'b1);
    predict(pc_for(8'h80));
    check("b2b_up_taken", pred_taken, 1);
    update(8'h80, 1'b0);
    update(8'h80, 1'b0);
    predict(pc_for(8'h80));
    check("b2b_down_taken", pred_taken, 0);

    // Random traffic focused on a few indices to force collisions
    for (int i = 0; i < 300; i++) begin
      pred_req  = 1'($urandom);
      upd_valid = 1'($urandom);
      upd_taken = 1'($urandom);
      upd_idx   = 8'h60 + 8'($urandom_range(0, 3));
      pred_pc   = ($urandom_range(0, 1) == 1) ? pc_for(upd_idx) : $urandom;
      cycle();
    end
    clear_inputs();
    @(posedge clk);
    #1;

    // Async reset in the middle of a lookup cycle
    pred_req = 1'b1;
    pred_pc  = 32'h0000_0044;
    @(posedge clk);
    #1;
    clear_inputs();
    check("pre_rst_valid", pred_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", pred_valid, 0);
    check("async_taken", pred_taken, 0);
    check("async_idx", pred_idx, 0);
    check("async_ghr", ghr_out, 0);
    check("async_busy", init_busy, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    wait_init(0);
    sweep_all_wnt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
